// File: rtl/multdiv_req_arbiter_pkg.sv
// Shared definitions for the multdiv request arbiter.
//   - md_op_e      : operator encoding understood by the multdiv unit
//   - arb_state_e  : arbiter sequencing states
//   - MD_MAX_LATENCY, BUSY_CNT_W and a saturating increment helper
package multdiv_req_arbiter_pkg;

  typedef enum logic [1:0] {
    MD_OP_MULL = 2'd0,
    MD_OP_MULH = 2'd1,
    MD_OP_DIV  = 2'd2,
    MD_OP_REM  = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  // Worst-case divide latency of the shared unit, in cycles.
  localparam int unsigned MD_MAX_LATENCY = 37;

  // Busy counter width; the counter saturates at 2^BUSY_CNT_W - 1.
  localparam int unsigned BUSY_CNT_W = 6;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [BUSY_CNT_W-1:0] sat_inc(input logic [BUSY_CNT_W-1:0] v);
    logic [BUSY_CNT_W-1:0] r;
    if (&v) begin
      r = v;
    end else begin
      r = v + {{(BUSY_CNT_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/multdiv_req_arbiter_rr_arbiter.sv
// Round-robin priority picker.
//   req_i   : request vector
//   ptr_i   : index of the last winner; search starts at (ptr_i+1) mod NUM_REQ
//   gnt_o   : one-hot grant (zero when no request)
//   idx_o   : index of the granted requester
//   valid_o : at least one request present
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 2,
  localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  // First requester found scanning upward from ptr_i+1, wrapping.
  always_comb begin : pick
    int unsigned j;
    j       = 0;
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      j = (32'(ptr_i) + i) % NUM_REQ;
      if (!valid_o && req_i[j]) begin
        valid_o  = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IDX_W'(j);
      end else begin
        valid_o = valid_o;
      end
    end
  end

endmodule

// File: rtl/multdiv_req_arbiter.sv
// Shares one multiply/divide unit between NUM_REQ requesters.
// Round-robin grant in IDLE latches the winner's operands, BUSY drives the
// unit handshake until md_valid_i, RESP holds the result for the owner.
// Ports:
//   clk_i, rst_ni                : clock, asynchronous active-low reset
//   req_*_i / req_ready_o        : per-requester request channel (packed)
//   rsp_valid_o/rsp_ready_i      : per-requester response handshake
//   rsp_result_o                 : shared result bus
//   md_*_o / md_valid_i/result_i : multdiv unit interface
//   busy_o, owner_o, timeout_o   : status (timeout is sticky)
module multdiv_req_arbiter
  import multdiv_req_arbiter_pkg::*;
#(
  parameter  int unsigned NUM_REQ     = 2,
  // Must exceed MD_MAX_LATENCY so a healthy divide never flags a timeout.
  parameter  int unsigned TIMEOUT_CYC = 48,
  localparam int unsigned IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  input  logic [2*NUM_REQ-1:0]    req_operator_i,
  input  logic [2*NUM_REQ-1:0]    req_signed_mode_i,
  input  logic [32*NUM_REQ-1:0]   req_op_a_i,
  input  logic [32*NUM_REQ-1:0]   req_op_b_i,
  output logic [NUM_REQ-1:0]      rsp_valid_o,
  input  logic [NUM_REQ-1:0]      rsp_ready_i,
  output logic [31:0]             rsp_result_o,
  output logic                    md_mult_en_o,
  output logic                    md_div_en_o,
  output logic                    md_mult_sel_o,
  output logic                    md_div_sel_o,
  output logic [1:0]              md_operator_o,
  output logic [1:0]              md_signed_mode_o,
  output logic [31:0]             md_op_a_o,
  output logic [31:0]             md_op_b_o,
  output logic                    md_ready_id_o,
  input  logic                    md_valid_i,
  input  logic [31:0]             md_result_i,
  output logic                    busy_o,
  output logic [IDX_W-1:0]        owner_o,
  output logic                    timeout_o
);

  localparam logic [BUSY_CNT_W-1:0] TIMEOUT_LIM = BUSY_CNT_W'(TIMEOUT_CYC);

  arb_state_e            state_q, state_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [IDX_W-1:0]      owner_q, owner_d;
  md_op_e                operator_q, operator_d;
  logic [1:0]            signed_q, signed_d;
  logic [31:0]           op_a_q, op_a_d;
  logic [31:0]           op_b_q, op_b_d;
  logic [31:0]           result_q, result_d;
  logic [BUSY_CNT_W-1:0] cnt_q, cnt_d;
  logic                  timeout_q, timeout_d;

  logic [NUM_REQ-1:0]    arb_gnt;
  logic [IDX_W-1:0]      arb_idx;
  logic                  arb_valid;
  logic                  op_is_div;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req_i   (req_valid_i),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  assign op_is_div = (operator_q == MD_OP_DIV) || (operator_q == MD_OP_REM);

  // Next-state logic: grant/latch in IDLE, wait for unit in BUSY, hand back in RESP.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    operator_d = operator_q;
    signed_d   = signed_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    result_d   = result_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (arb_valid) begin
          owner_d    = arb_idx;
          operator_d = md_op_e'(req_operator_i[{arb_idx, 1'b0} +: 2]);
          signed_d   = req_signed_mode_i[{arb_idx, 1'b0} +: 2];
          op_a_d     = req_op_a_i[{arb_idx, 5'b00000} +: 32];
          op_b_d     = req_op_b_i[{arb_idx, 5'b00000} +: 32];
          cnt_d      = '0;
          state_d    = ARB_BUSY;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_BUSY: begin
        cnt_d = sat_inc(cnt_q);
        // First md_valid_i wins; the unit is told ready every cycle so it
        // never holds the result.
        if (md_valid_i) begin
          result_d = md_result_i;
          state_d  = ARB_RESP;
        end else begin
          state_d = ARB_BUSY;
        end
      end
      ARB_RESP: begin
        // Only the owner's ready matters.
        if (rsp_ready_i[owner_q]) begin
          ptr_d   = owner_q;
          state_d = ARB_IDLE;
        end else begin
          state_d = ARB_RESP;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
    // Flag sets in the same edge the counter passes the limit.
    timeout_d = timeout_q | ((state_q == ARB_BUSY) && (cnt_d > TIMEOUT_LIM));
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ARB_IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      operator_q <= MD_OP_MULL;
      signed_q   <= 2'b00;
      op_a_q     <= 32'd0;
      op_b_q     <= 32'd0;
      result_q   <= 32'd0;
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      operator_q <= operator_d;
      signed_q   <= signed_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      result_q   <= result_d;
      cnt_q      <= cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  // Handshake outputs decoded from state; all low unless the state asks.
  always_comb begin
    req_ready_o   = '0;
    rsp_valid_o   = '0;
    md_mult_en_o  = 1'b0;
    md_div_en_o   = 1'b0;
    md_mult_sel_o = 1'b0;
    md_div_sel_o  = 1'b0;
    md_ready_id_o = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        // Gated by reset so no grant leaks out while rst_ni is low.
        if (rst_ni) begin
          req_ready_o = arb_gnt;
        end else begin
          req_ready_o = '0;
        end
      end
      ARB_BUSY: begin
        md_mult_en_o  = ~op_is_div;
        md_mult_sel_o = ~op_is_div;
        md_div_en_o   = op_is_div;
        md_div_sel_o  = op_is_div;
        md_ready_id_o = 1'b1;
      end
      ARB_RESP: begin
        rsp_valid_o[owner_q] = 1'b1;
      end
      default: begin
        req_ready_o = '0;
      end
    endcase
  end

  assign rsp_result_o     = result_q;
  assign md_operator_o    = operator_q;
  assign md_signed_mode_o = signed_q;
  assign md_op_a_o        = op_a_q;
  assign md_op_b_o        = op_b_q;
  assign busy_o           = (state_q != ARB_IDLE);
  assign owner_o          = owner_q;
  assign timeout_o        = timeout_q;

endmodule

// File: tb/tb_multdiv_req_arbiter.sv
// Directed bench for multdiv_req_arbiter (NUM_REQ = 2). The multdiv unit is
// stubbed by driving md_valid_i/md_result_i with hand-computed results.
module tb_multdiv_req_arbiter;

  localparam int N = 2;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [N-1:0]  req_valid_i;
  logic [N-1:0]  req_ready_o;
  logic [2*N-1:0]  req_operator_i;
  logic [2*N-1:0]  req_signed_mode_i;
  logic [32*N-1:0] req_op_a_i;
  logic [32*N-1:0] req_op_b_i;
  logic [N-1:0]  rsp_valid_o;
  logic [N-1:0]  rsp_ready_i;
  logic [31:0]   rsp_result_o;
  logic          md_mult_en_o, md_div_en_o, md_mult_sel_o, md_div_sel_o;
  logic [1:0]    md_operator_o, md_signed_mode_o;
  logic [31:0]   md_op_a_o, md_op_b_o;
  logic          md_ready_id_o;
  logic          md_valid_i;
  logic [31:0]   md_result_i;
  logic          busy_o;
  logic          owner_o;
  logic          timeout_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  multdiv_req_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(48)) dut (
    .clk_i (clk_i), .rst_ni (rst_ni),
    .req_valid_i (req_valid_i), .req_ready_o (req_ready_o),
    .req_operator_i (req_operator_i), .req_signed_mode_i (req_signed_mode_i),
    .req_op_a_i (req_op_a_i), .req_op_b_i (req_op_b_i),
    .rsp_valid_o (rsp_valid_o), .rsp_ready_i (rsp_ready_i), .rsp_result_o (rsp_result_o),
    .md_mult_en_o (md_mult_en_o), .md_div_en_o (md_div_en_o),
    .md_mult_sel_o (md_mult_sel_o), .md_div_sel_o (md_div_sel_o),
    .md_operator_o (md_operator_o), .md_signed_mode_o (md_signed_mode_o),
    .md_op_a_o (md_op_a_o), .md_op_b_o (md_op_b_o),
    .md_ready_id_o (md_ready_id_o), .md_valid_i (md_valid_i), .md_result_i (md_result_i),
    .busy_o (busy_o), .owner_o (owner_o), .timeout_o (timeout_o)
  );

  task automatic step;
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(input int r, input logic [1:0] op, input logic [1:0] sm,
                       input logic [31:0] a, input logic [31:0] b);
    req_valid_i[r]              = 1'b1;
    req_operator_i[2*r +: 2]    = op;
    req_signed_mode_i[2*r +: 2] = sm;
    req_op_a_i[32*r +: 32]      = a;
    req_op_b_i[32*r +: 32]      = b;
    #1;
  endtask

  task automatic test_reset;
    rst_ni = 1'b0;
    req_valid_i = '0; req_operator_i = '0; req_signed_mode_i = '0;
    req_op_a_i = '0; req_op_b_i = '0; rsp_ready_i = 2'b11;
    md_valid_i = 1'b0; md_result_i = 32'd0;
    step; step;
    total++; if (req_ready_o !== 2'b00) begin bad++; $display("FAIL reset_req_ready: got %b want 00", req_ready_o); end
    total++; if (rsp_valid_o !== 2'b00) begin bad++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid_o); end
    total++; if (rsp_result_o !== 32'd0) begin bad++; $display("FAIL reset_result: got %h want 0", rsp_result_o); end
    total++; if ({md_mult_en_o, md_div_en_o, md_mult_sel_o, md_div_sel_o, md_ready_id_o} !== 5'b00000) begin
      bad++; $display("FAIL reset_md_ctrl: got %b want 00000", {md_mult_en_o, md_div_en_o, md_mult_sel_o, md_div_sel_o, md_ready_id_o}); end
    total++; if ({busy_o, owner_o, timeout_o} !== 3'b000) begin bad++; $display("FAIL reset_status: got %b want 000", {busy_o, owner_o, timeout_o}); end
    total++; if ({md_op_a_o, md_op_b_o, md_operator_o, md_signed_mode_o} !== 68'd0) begin bad++; $display("FAIL reset_operands: got %h want 0", {md_op_a_o, md_op_b_o}); end
    rst_ni = 1'b1;
    step;
  endtask

  // Req0 MULL 7*6 with unit latency 3, rsp_ready tied high.
  task automatic test_mull;
    bit ok;
    issue(0, 2'd0, 2'b00, 32'd7, 32'd6);
    total++; if (req_ready_o !== 2'b01) begin bad++; $display("FAIL mull_grant: got %b want 01", req_ready_o); end
    step;
    req_valid_i = '0; #1;
    total++; if (req_ready_o !== 2'b00) begin bad++; $display("FAIL mull_ready_pulse: got %b want 00", req_ready_o); end
    total++; if (md_op_a_o !== 32'd7 || md_op_b_o !== 32'd6 || owner_o !== 1'b0) begin
      bad++; $display("FAIL mull_latch: got a=%0d b=%0d owner=%0d want 7 6 0", md_op_a_o, md_op_b_o, owner_o); end
    ok = 1'b1;
    repeat (2) begin
      if (!(md_mult_en_o && md_mult_sel_o && !md_div_en_o && md_ready_id_o && busy_o)) ok = 1'b0;
      step;
    end
    md_valid_i = 1'b1; md_result_i = 32'd42; #1;
    if (!(md_mult_en_o && md_ready_id_o)) ok = 1'b0;
    total++; if (!ok) begin bad++; $display("FAIL mull_enable_hold: got drop want mult_en held 3 cycles"); end
    step;
    md_valid_i = 1'b0; md_result_i = 32'd0;
    total++; if (rsp_valid_o !== 2'b01 || rsp_result_o !== 32'd42) begin
      bad++; $display("FAIL mull_rsp: got valid=%b res=%0d want 01 42", rsp_valid_o, rsp_result_o); end
    total++; if (md_mult_en_o !== 1'b0) begin bad++; $display("FAIL mull_en_off: got %b want 0", md_mult_en_o); end
    step;
    total++; if (rsp_valid_o !== 2'b00 || busy_o !== 1'b0) begin
      bad++; $display("FAIL mull_done: got valid=%b busy=%b want 00 0", rsp_valid_o, busy_o); end
  endtask

  // Req1 signed DIV -20/3 = -6 with the worst-case 37-cycle latency.
  task automatic test_div;
    bit ok;
    issue(1, 2'd2, 2'b11, 32'hFFFF_FFEC, 32'd3);
    total++; if (req_ready_o !== 2'b10) begin bad++; $display("FAIL div_grant: got %b want 10", req_ready_o); end
    step;
    req_valid_i = '0; #1;
    total++; if (md_operator_o !== 2'd2 || md_signed_mode_o !== 2'b11 || md_op_a_o !== 32'hFFFF_FFEC) begin
      bad++; $display("FAIL div_latch: got op=%0d sm=%b a=%h want 2 11 ffffffec", md_operator_o, md_signed_mode_o, md_op_a_o); end
    ok = 1'b1;
    repeat (36) begin
      if (!(md_div_en_o && md_div_sel_o && !md_mult_en_o && owner_o == 1'b1 && md_op_b_o == 32'd3)) ok = 1'b0;
      step;
    end
    total++; if (!ok) begin bad++; $display("FAIL div_enable_hold: got drop want div_en/owner=1 held"); end
    md_valid_i = 1'b1; md_result_i = 32'hFFFF_FFFA;
    step;
    md_valid_i = 1'b0; md_result_i = 32'd0;
    total++; if (rsp_valid_o !== 2'b10 || rsp_result_o !== 32'hFFFF_FFFA || owner_o !== 1'b1) begin
      bad++; $display("FAIL div_rsp: got valid=%b res=%h owner=%0d want 10 fffffffa 1", rsp_valid_o, rsp_result_o, owner_o); end
    step;
  endtask

  // Both requesters always valid: grants rotate and results follow the owner.
  task automatic test_fairness;
    int exp_g [4] = '{0, 1, 0, 1};
    logic [1:0]  oh;
    logic [31:0] exp_r;
    issue(0, 2'd3, 2'b00, 32'd17, 32'd5);
    issue(1, 2'd1, 2'b00, 32'h8000_0000, 32'd2);
    for (int g = 0; g < 4; g++) begin
      oh    = (exp_g[g] == 0) ? 2'b01 : 2'b10;
      exp_r = (exp_g[g] == 0) ? 32'd2 : 32'd1;
      total++; if (req_ready_o !== oh) begin bad++; $display("FAIL fair_grant%0d: got %b want %b", g, req_ready_o, oh); end
      step;
      total++; if (owner_o !== 1'(exp_g[g]) || req_ready_o !== 2'b00) begin
        bad++; $display("FAIL fair_busy%0d: got owner=%0d ready=%b want %0d 00", g, owner_o, req_ready_o, exp_g[g]); end
      step;
      md_valid_i = 1'b1; md_result_i = exp_r;
      step;
      md_valid_i = 1'b0; md_result_i = 32'd0;
      total++; if (rsp_valid_o !== oh || rsp_result_o !== exp_r) begin
        bad++; $display("FAIL fair_rsp%0d: got valid=%b res=%h want %b %h", g, rsp_valid_o, rsp_result_o, oh, exp_r); end
      step;
    end
    req_valid_i = '0; #1;
  endtask

  // Owner stalls rsp_ready for 5 cycles; non-owner ready is ignored.
  task automatic test_rsp_delay;
    bit ok;
    rsp_ready_i = 2'b00;
    issue(0, 2'd0, 2'b00, 32'd3, 32'd5);
    issue(1, 2'd0, 2'b00, 32'd4, 32'd4);
    total++; if (req_ready_o !== 2'b01) begin bad++; $display("FAIL delay_grant0: got %b want 01", req_ready_o); end
    step;
    md_valid_i = 1'b1; md_result_i = 32'd15;
    step;
    md_valid_i = 1'b0; md_result_i = 32'd0;
    rsp_ready_i = 2'b10; #1;
    ok = 1'b1;
    repeat (5) begin
      if (!(rsp_valid_o == 2'b01 && rsp_result_o == 32'd15 && req_ready_o == 2'b00 && busy_o)) ok = 1'b0;
      step;
    end
    total++; if (!ok) begin bad++; $display("FAIL delay_hold: got change want rsp held, no grant"); end
    rsp_ready_i = 2'b01;
    step;
    total++; if (req_ready_o !== 2'b10 || busy_o !== 1'b0) begin
      bad++; $display("FAIL delay_next_grant: got ready=%b busy=%b want 10 0", req_ready_o, busy_o); end
    step;
    req_valid_i = '0; #1;
    total++; if (owner_o !== 1'b1 || md_op_a_o !== 32'd4) begin bad++; $display("FAIL delay_owner1: got owner=%0d a=%0d want 1 4", owner_o, md_op_a_o); end
    md_valid_i = 1'b1; md_result_i = 32'd16;
    step;
    md_valid_i = 1'b0; md_result_i = 32'd0;
    total++; if (rsp_valid_o !== 2'b10 || rsp_result_o !== 32'd16) begin
      bad++; $display("FAIL delay_rsp1: got valid=%b res=%0d want 10 16", rsp_valid_o, rsp_result_o); end
    rsp_ready_i = 2'b11;
    step;
  endtask

  // Unit withholds md_valid_i for 60 BUSY cycles.
  task automatic test_timeout;
    bit ok;
    issue(0, 2'd2, 2'b00, 32'd100, 32'd7);
    total++; if (req_ready_o !== 2'b01) begin bad++; $display("FAIL to_grant: got %b want 01", req_ready_o); end
    step;
    req_valid_i = '0; #1;
    ok = 1'b1;
    for (int k = 1; k <= 48; k++) begin
      step;
      if (timeout_o !== 1'b0) ok = 1'b0;
    end
    total++; if (!ok) begin bad++; $display("FAIL to_early: got timeout=1 want 0 through 48 busy cycles"); end
    step;
    total++; if (timeout_o !== 1'b1) begin bad++; $display("FAIL to_set: got %b want 1 after 49 busy cycles", timeout_o); end
    repeat (10) step;
    total++; if (!(busy_o && md_div_en_o && timeout_o)) begin
      bad++; $display("FAIL to_still_busy: got busy=%b div_en=%b to=%b want 111", busy_o, md_div_en_o, timeout_o); end
    md_valid_i = 1'b1; md_result_i = 32'd14;
    step;
    md_valid_i = 1'b0; md_result_i = 32'd0;
    total++; if (rsp_valid_o !== 2'b01 || rsp_result_o !== 32'd14) begin
      bad++; $display("FAIL to_rsp: got valid=%b res=%0d want 01 14", rsp_valid_o, rsp_result_o); end
    step;
    total++; if (busy_o !== 1'b0 || timeout_o !== 1'b1) begin
      bad++; $display("FAIL to_sticky: got busy=%b to=%b want 0 1", busy_o, timeout_o); end
  endtask

  // Asynchronous reset mid-divide, then a fresh operation.
  task automatic test_reset_mid;
    issue(1, 2'd2, 2'b00, 32'd50, 32'd5);
    total++; if (req_ready_o !== 2'b10) begin bad++; $display("FAIL rm_grant: got %b want 10", req_ready_o); end
    step;
    req_valid_i = '0;
    repeat (10) step;
    total++; if (busy_o !== 1'b1 || md_div_en_o !== 1'b1) begin bad++; $display("FAIL rm_busy: got busy=%b div_en=%b want 1 1", busy_o, md_div_en_o); end
    #1;
    issue(0, 2'd0, 2'b00, 32'd9, 32'd9);
    rst_ni = 1'b0; #1;
    total++; if ({busy_o, owner_o, timeout_o, md_div_en_o, md_div_sel_o, md_ready_id_o} !== 6'b000000) begin
      bad++; $display("FAIL rm_async_ctrl: got %b want 000000", {busy_o, owner_o, timeout_o, md_div_en_o, md_div_sel_o, md_ready_id_o}); end
    total++; if (md_op_a_o !== 32'd0 || md_operator_o !== 2'd0 || req_ready_o !== 2'b00 || rsp_valid_o !== 2'b00) begin
      bad++; $display("FAIL rm_async_data: got a=%h op=%0d ready=%b valid=%b want 0 0 00 00", md_op_a_o, md_operator_o, req_ready_o, rsp_valid_o); end
    step; step;
    rst_ni = 1'b1; #1;
    total++; if (req_ready_o !== 2'b01) begin bad++; $display("FAIL rm_fresh_grant: got %b want 01", req_ready_o); end
    step;
    req_valid_i = '0; #1;
    total++; if (md_mult_en_o !== 1'b1 || md_op_a_o !== 32'd9) begin
      bad++; $display("FAIL rm_fresh_busy: got mult_en=%b a=%0d want 1 9", md_mult_en_o, md_op_a_o); end
    md_valid_i = 1'b1; md_result_i = 32'd81;
    step;
    md_valid_i = 1'b0; md_result_i = 32'd0;
    total++; if (rsp_valid_o !== 2'b01 || rsp_result_o !== 32'd81) begin
      bad++; $display("FAIL rm_fresh_rsp: got valid=%b res=%0d want 01 81", rsp_valid_o, rsp_result_o); end
    step;
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL rm_fresh_idle: got busy=%b want 0", busy_o); end
  endtask

  initial begin
    test_reset;
    test_mull;
    test_div;
    test_fairness;
    test_rsp_delay;
    test_timeout;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got still running want finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/multdiv_req_arbiter.md
Name: multdiv_req_arbiter

Overview:
- Shares one fast multiply/divide unit between NUM_REQ requesters, e.g. the core ID stage and a debug/accelerator port.
- Arbitrates with a round-robin policy and latches the winner's operands.
- Sequences the unit's enable/select/ready-ID handshake, captures the result and returns it on a valid/ready response channel to the owning requester.
- Sits between the requesters and the multdiv datapath. ALU adder sharing stays outside this block.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- TIMEOUT_CYC, 48, busy cycles before the sticky timeout flag sets; must exceed worst-case divide latency (37).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  NUM_REQ  per-requester request valid
- req_ready_o  out  NUM_REQ  per-requester request accept (one-hot or zero)
- req_operator_i  in  2*NUM_REQ  operator per requester: 0 MULL, 1 MULH, 2 DIV, 3 REM
- req_signed_mode_i  in  2*NUM_REQ  {b signed, a signed} per requester
- req_op_a_i  in  32*NUM_REQ  operand A per requester
- req_op_b_i  in  32*NUM_REQ  operand B per requester
- rsp_valid_o  out  NUM_REQ  result valid to the owner
- rsp_ready_i  in  NUM_REQ  result accept from the owner
- rsp_result_o  out  32  result, shared bus, qualified by rsp_valid_o
- md_mult_en_o  out  1  multiplier enable
- md_div_en_o  out  1  divider enable
- md_mult_sel_o  out  1  multiplier select
- md_div_sel_o  out  1  divider select
- md_operator_o  out  2  latched operator
- md_signed_mode_o  out  2  latched signed mode
- md_op_a_o  out  32  latched operand A
- md_op_b_o  out  32  latched operand B
- md_ready_id_o  out  1  ready-ID to the unit
- md_valid_i  in  1  unit result valid
- md_result_i  in  32  unit result
- busy_o  out  1  operation in flight (BUSY or RESP)
- owner_o  out  clog2(NUM_REQ)  index of the current owner
- timeout_o  out  1  sticky, set when a busy count exceeds TIMEOUT_CYC

Behaviour:
- Reset values:
  - all outputs 0; state IDLE; round-robin pointer 0.
  - operand, operator and result registers 0; busy counter 0; timeout_o 0.
- States: IDLE, BUSY, RESP.
- IDLE:
  - If any req_valid_i is high, grant the first valid requester searching upward from (ptr+1) mod NUM_REQ, wrapping.
  - req_ready_o[g] is high combinationally for that cycle only.
  - Latch operator, signed mode, A and B; owner <= g; go to BUSY next cycle.
  - No md_*_en in IDLE.
- BUSY:
  - md_mult_en_o = md_mult_sel_o = ~operator[1].
  - md_div_en_o = md_div_sel_o = operator[1].
  - md_ready_id_o = 1, so the unit never holds and returns to its idle state on the valid cycle.
  - Operand outputs come from registers and are stable for the whole operation.
  - On md_valid_i: capture md_result_i, go to RESP, deassert enables next cycle.
- RESP:
  - rsp_valid_o[owner] = 1; rsp_result_o = captured result.
  - On rsp_ready_i[owner]: ptr <= owner; go to IDLE.
  - The next grant can occur in the following IDLE cycle.
- Minimum turnaround is 1 accept cycle + unit latency + 1 response cycle. Back-to-back requests are never accepted while BUSY or RESP.
- req_ready_o is never asserted to more than one requester and never outside IDLE.
- rsp_ready_i of non-owners is ignored. rsp_valid_o stays high until accepted.
- Requests that are valid but not granted wait; the arbiter has no obligation to hold them. A requester that drops valid before grant loses nothing.
- md_valid_i outside BUSY is ignored. In BUSY it is accepted on its first occurrence.
- Busy counter:
  - increments each BUSY cycle, saturates at 2^6-1, clears on entry to BUSY.
  - timeout_o sets when count > TIMEOUT_CYC and clears only by reset. The operation still completes.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,NUM_REQ-1.
- busy_o = (state != IDLE). owner_o is held from grant until return to IDLE.
- Asynchronous reset mid-operation returns to IDLE immediately with all outputs 0. The multdiv unit shares rst_ni, so no stale internal state survives.

Decomposition:
- Shared multdiv package holds:
  - the operator enum (MD_OP_MULL/MULH/DIV/REM);
  - the arbiter state enum;
  - the constant MD_MAX_LATENCY = 37.
- One sub-module, rr_arbiter (NUM_REQ-wide round-robin priority picker: req vector + pointer -> one-hot grant and index), is natural and reusable.

Test Plan:
- Req0 MULL A=7, B=6; rsp_ready tied 1 -> req_ready_o[0] pulses once, md_mult_en_o high for the unit latency, rsp_result_o=42, rsp_valid_o[0] for 1 cycle, busy_o then 0.
- Req1 DIV A=-20 (0xFFFFFFEC), B=3, signed 2'b11 -> md_div_en_o held until md_valid_i; rsp_result_o=0xFFFFFFFA (-6); owner_o=1 throughout.
- Both valid continuously with REM 17%5 and MULH 0x80000000*2 -> grants alternate 0,1,0,1; results 2 and 0x00000001 (unsigned) are routed to the correct owner.
- Owner delays rsp_ready_i by 5 cycles -> rsp_valid_o and result held stable; no new req_ready_o during the wait; other requester granted the cycle after IDLE re-entry.
- Stub unit withholds md_valid_i for 60 cycles -> timeout_o sets at cycle 49 and stays set; completion still returns the result.
- rst_ni asserted in BUSY mid-divide -> all outputs 0 asynchronously; after release, a fresh request completes correctly.
